execute_operand_stage: RTL
==========================

// Module: execute_operand_stage
// PURPOSE
//  ID->EX pipeline register that drives ALU_Control/operand_A/operand_B into the execute-stage ALU.
//  Each cycle it captures one decoded instruction, applies register bypass from later stages,
//  handles stall and flush, and detects load-use hazards.
// PARAMETERS
//  DATA_WIDTH  32  datapath width (matches ALU)
//  REG_BITS    5   register index width
// PORTS
//  clock            in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high
//  stall            in   1           hold current entry
//  flush            in   1           replace entry with bubble
//  in_valid         in   1           decode slot holds an instruction
//  in_ALU_Control   in   6           ALU opcode from decode
//  in_rs1/in_rs2    in   REG_BITS    source register indices
//  in_rs1_data      in   DATA_WIDTH  regfile read of rs1
//  in_rs2_data      in   DATA_WIDTH  regfile read of rs2
//  in_imm           in   DATA_WIDTH  sign-extended immediate
//  in_pc            in   DATA_WIDTH  instruction PC
//  in_a_sel         in   2           00 rs1, 01 PC, 10 PC+4, 11 zero
//  in_b_sel         in   1           0 rs2, 1 imm
//  in_rd            in   REG_BITS    destination register
//  in_regwrite      in   1           instruction writes rd
//  mem_rd, mem_regwrite, mem_data, mem_is_load  in  REG_BITS,1,DATA_WIDTH,1  EX/MEM bypass source
//  wb_rd, wb_regwrite, wb_data      in   REG_BITS,1,DATA_WIDTH  MEM/WB bypass source (macro only)
//  ALU_Control      out  6           to ALU
//  operand_A        out  DATA_WIDTH  to ALU
//  operand_B        out  DATA_WIDTH  to ALU
//  store_data       out  DATA_WIDTH  forwarded rs2 value for stores
//  out_valid, out_rd, out_regwrite  out  1,REG_BITS,1  forwarded down the pipe
//  load_use_hazard  out  1           combinational; upstream must stall
// BEHAVIOUR
//  - Reset (async): out_valid=0, ALU_Control=6'b000_000, operands/store_data=0, out_rd=0, out_regwrite=0.
//  - Latency 1: inputs presented at edge N appear on outputs after edge N.
//  - Internal regs: rs1_q, rs2_q, rs1_val, rs2_val, imm_q, pc_q, a_sel_q, b_sel_q.
//    operand_A = {rs1_val, pc_q, pc_q+4, 0}[a_sel_q]; operand_B = b_sel_q ? imm_q : rs2_val;
//    store_data = rs2_val. PC+4 wraps modulo 2^DATA_WIDTH.
//  - Bypass on capture, per source: mem match (regwrite & rd==rs & rs!=0 & !mem_is_load) beats
//    wb match, which beats regfile data. x0 is never forwarded.
//  - load_use_hazard = in_valid & mem_is_load & mem_regwrite & mem_rd!=0 &
//    (mem_rd==in_rs1 | mem_rd==in_rs2).
//  - Edge priority:
//      1) flush: bubble.
//      2) stall: hold all fields; rs1_val/rs2_val are refreshed when a bypass source matches
//         rs1_q/rs2_q (mem_is_load suppresses the mem refresh), so a value is not lost while held.
//      3) load_use_hazard: bubble.
//      4) otherwise: capture; out_valid=in_valid.
//  - Bubble: out_valid=0, ALU_Control=6'b000_000, out_regwrite=0, out_rd=0.
//    Operand registers are don't-care but must not be X.
//  - flush and stall both high: flush wins. Reset mid-stall returns to the reset state immediately.
// CONFIGURATION
//  EX_WB_BYPASS_EN defined: the wb_* source participates, below mem priority.
//  Not defined: wb_* ports still exist but are ignored; regfile data is used (regfile must be
//  write-first).
// TESTING
//  1. Reset asserted mid-cycle -> outputs go to reset values immediately (before the next edge).
//  2. ADD x3,x1,x2 with in_rs1_data=5, in_rs2_data=7, sel 00/0 -> next cycle ALU_Control=000_000,
//     A=5, B=7, out_valid=1.
//  3. mem_rd=1, mem_regwrite=1, mem_data=0x55, regfile rs1=0x11 -> A=0x55; same with rs1=x0 -> A=0.
//  4. mem_is_load=1, mem_rd=2, in_rs2=2 -> load_use_hazard=1; next cycle out_valid=0,
//     ALU_Control=0.
//  5. Stall 3 cycles holding rs1=4, wb_rd=4, wb_data=0x99 in cycle 2 (macro on) -> A=0x99 after
//     release; macro off -> A keeps its old value.
//  6. JAL: a_sel=10, pc=0xFFFFFFFC, ALU_Control=011_111 -> A=0x00000000; flush+stall together
//     -> bubble.

Source files
------------

// File: rtl/execute_operand_stage.sv
// ID->EX pipeline register: captures one decoded instruction per cycle, bypasses operands, drives the ALU.
// Optional macro EX_WB_BYPASS_EN adds the MEM/WB result as a bypass source below EX/MEM.
module execute_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [5:0]            in_ALU_Control,
    input  logic [REG_BITS-1:0]   in_rs1,
    input  logic [REG_BITS-1:0]   in_rs2,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [1:0]            in_a_sel,
    input  logic                  in_b_sel,
    input  logic [REG_BITS-1:0]   in_rd,
    input  logic                  in_regwrite,
    input  logic [REG_BITS-1:0]   mem_rd,
    input  logic                  mem_regwrite,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_is_load,
    input  logic [REG_BITS-1:0]   wb_rd,
    input  logic                  wb_regwrite,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [5:0]            ALU_Control,
    output logic [DATA_WIDTH-1:0] operand_A,
    output logic [DATA_WIDTH-1:0] operand_B,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic                  out_valid,
    output logic [REG_BITS-1:0]   out_rd,
    output logic                  out_regwrite,
    output logic                  load_use_hazard
);

    logic [5:0]            alu_ctrl_q;
    logic                  valid_q;
    logic [REG_BITS-1:0]   rd_q;
    logic                  regwrite_q;
    logic [REG_BITS-1:0]   rs1_q;
    logic [REG_BITS-1:0]   rs2_q;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [1:0]            a_sel_q;
    logic                  b_sel_q;

    // Index 0 is the rs1 path, index 1 the rs2 path.
    logic [REG_BITS-1:0]   cap_rs      [2];
    logic [REG_BITS-1:0]   held_rs     [2];
    logic [DATA_WIDTH-1:0] rf_data     [2];
    logic [DATA_WIDTH-1:0] held_val    [2];
    logic [DATA_WIDTH-1:0] cap_val     [2];
    logic [DATA_WIDTH-1:0] refresh_val [2];

    assign cap_rs[0]   = in_rs1;
    assign cap_rs[1]   = in_rs2;
    assign held_rs[0]  = rs1_q;
    assign held_rs[1]  = rs2_q;
    assign rf_data[0]  = in_rs1_data;
    assign rf_data[1]  = in_rs2_data;
    assign held_val[0] = rs1_val;
    assign held_val[1] = rs2_val;

`ifndef EX_WB_BYPASS_EN
    logic wb_unused;
    assign wb_unused = wb_regwrite ^ (^wb_rd) ^ (^wb_data);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            logic mem_cap_hit;
            logic mem_hold_hit;
            logic wb_cap_hit;
            logic wb_hold_hit;

            // A load result is not available yet, so EX/MEM loads never forward.
            assign mem_cap_hit  = mem_regwrite && !mem_is_load && (cap_rs[gi] != '0)
                                  && (mem_rd == cap_rs[gi]);
            assign mem_hold_hit = mem_regwrite && !mem_is_load && (held_rs[gi] != '0)
                                  && (mem_rd == held_rs[gi]);
`ifdef EX_WB_BYPASS_EN
            assign wb_cap_hit   = wb_regwrite && (cap_rs[gi] != '0) && (wb_rd == cap_rs[gi]);
            assign wb_hold_hit  = wb_regwrite && (held_rs[gi] != '0) && (wb_rd == held_rs[gi]);
            assign cap_val[gi]     = mem_cap_hit  ? mem_data : (wb_cap_hit  ? wb_data : rf_data[gi]);
            assign refresh_val[gi] = mem_hold_hit ? mem_data : (wb_hold_hit ? wb_data : held_val[gi]);
`else
            assign wb_cap_hit   = 1'b0;
            assign wb_hold_hit  = 1'b0;
            assign cap_val[gi]     = mem_cap_hit  ? mem_data : rf_data[gi];
            assign refresh_val[gi] = mem_hold_hit ? mem_data : held_val[gi];
`endif
        end
    endgenerate

    assign load_use_hazard = in_valid && mem_is_load && mem_regwrite && (mem_rd != '0)
                             && ((mem_rd == in_rs1) || (mem_rd == in_rs2));

    // Bubbles clear only control fields; operand registers keep their last defined value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            alu_ctrl_q <= 6'b000_000;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_val    <= '0;
            rs2_val    <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            a_sel_q    <= 2'b00;
            b_sel_q    <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            alu_ctrl_q <= 6'b000_000;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else if (stall) begin
            rs1_val <= refresh_val[0];
            rs2_val <= refresh_val[1];
        end else if (load_use_hazard) begin
            valid_q    <= 1'b0;
            alu_ctrl_q <= 6'b000_000;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else begin
            valid_q    <= in_valid;
            alu_ctrl_q <= in_ALU_Control;
            rd_q       <= in_rd;
            regwrite_q <= in_regwrite;
            rs1_q      <= in_rs1;
            rs2_q      <= in_rs2;
            rs1_val    <= cap_val[0];
            rs2_val    <= cap_val[1];
            imm_q      <= in_imm;
            pc_q       <= in_pc;
            a_sel_q    <= in_a_sel;
            b_sel_q    <= in_b_sel;
        end
    end

    always_comb begin
        operand_A = '0;
        case (a_sel_q)
            2'b00:   operand_A = rs1_val;
            2'b01:   operand_A = pc_q;
            2'b10:   operand_A = pc_q + DATA_WIDTH'(4);
            default: operand_A = '0;
        endcase
    end

    assign operand_B    = b_sel_q ? imm_q : rs2_val;
    assign store_data   = rs2_val;
    assign ALU_Control  = alu_ctrl_q;
    assign out_valid    = valid_q;
    assign out_rd       = rd_q;
    assign out_regwrite = regwrite_q;

endmodule
